// File: rtl/vga_mode_ctrl.sv
// Run-time VGA mode sequencer: accepts a mode request, waits for a frame boundary,
// loads the mode's timing fields with a one-cycle strobe, then keeps video blanked while the new timing settles.
module vga_mode_ctrl #(
  parameter int DEFAULT_MODE  = 0,
  parameter int TW            = 12,
  parameter int SETTLE_FRAMES = 2,
  parameter int TIMEOUT       = 2000000
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          mode_req_valid_i,
  input  logic [1:0]    mode_req_i,
  output logic          mode_req_ready_o,
  input  logic          frame_end_i,
  output logic [TW-1:0] hd_o,
  output logic [TW-1:0] hf_o,
  output logic [TW-1:0] hr_o,
  output logic [TW-1:0] hb_o,
  output logic [TW-1:0] vd_o,
  output logic [TW-1:0] vf_o,
  output logic [TW-1:0] vr_o,
  output logic [TW-1:0] vb_o,
  output logic          h_pol_o,
  output logic          v_pol_o,
  output logic [15:0]   div_by_o,
  output logic          we_o,
  output logic          blank_o,
  output logic          busy_o,
  output logic [1:0]    cur_mode_o,
  output logic          timeout_o
);

  localparam int TMW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int FW  = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [TMW-1:0] T_LAST  = TMW'(TIMEOUT - 1);
  localparam logic [1:0]     DEF_MODE = 2'(DEFAULT_MODE);

  typedef struct packed {
    logic [TW-1:0] hd, hf, hr, hb, vd, vf, vr, vb;
    logic          h_pol, v_pol;
    logic [15:0]   div_by;
  } timing_t;

  typedef enum logic [2:0] {BOOT, IDLE, WAIT_FRAME, LOAD, SETTLE} state_t;

  function automatic timing_t mode_entry(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{TW'(640),  TW'(16), TW'(96),  TW'(48),  TW'(480), TW'(10), TW'(2), TW'(33), 1'b0, 1'b0, 16'h338F};
      2'd1:    t = '{TW'(800),  TW'(40), TW'(128), TW'(88),  TW'(600), TW'(1),  TW'(4), TW'(23), 1'b1, 1'b1, 16'h51EC};
      2'd2:    t = '{TW'(1024), TW'(24), TW'(136), TW'(160), TW'(768), TW'(3),  TW'(6), TW'(29), 1'b0, 1'b0, 16'h851F};
      default: t = '{TW'(1366), TW'(70), TW'(143), TW'(213), TW'(768), TW'(3),  TW'(3), TW'(24), 1'b1, 1'b1, 16'hAF1B};
    endcase
    return t;
  endfunction

  state_t         state_reg, state_next;
  logic [1:0]     pending_reg, pending_next;
  logic [1:0]     cur_mode_reg, cur_mode_next;
  logic [TMW-1:0] timer_reg, timer_next;
  logic [FW-1:0]  frames_reg, frames_next;
  logic           timeout_reg, timeout_next;
  timing_t        timing_reg, timing_next;
  logic           load_now;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg    <= BOOT;
      pending_reg  <= DEF_MODE;
      cur_mode_reg <= DEF_MODE;
      timer_reg    <= '0;
      frames_reg   <= '0;
      timeout_reg  <= 1'b0;
      timing_reg   <= mode_entry(DEF_MODE);
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      cur_mode_reg <= cur_mode_next;
      timer_reg    <= timer_next;
      frames_reg   <= frames_next;
      timeout_reg  <= timeout_next;
      timing_reg   <= timing_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    timer_next   = timer_reg;
    frames_next  = frames_reg;
    timeout_next = 1'b0;
    load_now     = 1'b0;
    case (state_reg)
      BOOT: begin
        pending_next = DEF_MODE;
        state_next   = LOAD;
        load_now     = 1'b1;
      end
      IDLE: begin
        // A request for the mode already programmed is consumed without a reload.
        if (mode_req_valid_i && (mode_req_i != cur_mode_reg)) begin
          pending_next = mode_req_i;
          timer_next   = '0;
          state_next   = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_end_i) begin
          state_next = LOAD;
          load_now   = 1'b1;
        end else if (timer_reg == T_LAST) begin
          state_next   = LOAD;
          load_now     = 1'b1;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer_reg + TMW'(1);
        end
      end
      LOAD: begin
        timer_next  = '0;
        frames_next = '0;
        state_next  = (SETTLE_FRAMES == 0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        // A missing frame_end_i still counts as a frame once the timer expires.
        if (frame_end_i || (timer_reg == T_LAST)) begin
          timeout_next = !frame_end_i;
          timer_next   = '0;
          if (int'(frames_reg) + 1 >= SETTLE_FRAMES) state_next = IDLE;
          else frames_next = frames_reg + FW'(1);
        end else begin
          timer_next = timer_reg + TMW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    cur_mode_next = load_now ? pending_next : cur_mode_reg;
    timing_next   = load_now ? mode_entry(pending_next) : timing_reg;
  end

  assign we_o             = (state_reg == LOAD);
  assign mode_req_ready_o = (state_reg == IDLE);
  assign busy_o           = (state_reg != IDLE);
  assign blank_o          = (state_reg != IDLE) && (state_reg != WAIT_FRAME);
  assign timeout_o        = timeout_reg;
  assign cur_mode_o       = cur_mode_reg;
  assign hd_o             = timing_reg.hd;
  assign hf_o             = timing_reg.hf;
  assign hr_o             = timing_reg.hr;
  assign hb_o             = timing_reg.hb;
  assign vd_o             = timing_reg.vd;
  assign vf_o             = timing_reg.vf;
  assign vr_o             = timing_reg.vr;
  assign vb_o             = timing_reg.vb;
  assign h_pol_o          = timing_reg.h_pol;
  assign v_pol_o          = timing_reg.v_pol;
  assign div_by_o         = timing_reg.div_by;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl: table-driven mode loads plus directed
// sequences for boot, same-mode requests, wait timeout, coincident events and reset.
module tb_vga_mode_ctrl;

  logic        clk = 1'b0;
  logic        arstn;
  logic        valid;
  logic [1:0]  mode;
  logic        ready;
  logic        frame_end;
  logic [11:0] hd, hf, hr, hb, vd, vf, vr, vb;
  logic        hpol, vpol;
  logic [15:0] div_by;
  logic        we, blank, busy, timeout;
  logic [1:0]  cur_mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_mode_ctrl #(.DEFAULT_MODE(0), .TW(12), .SETTLE_FRAMES(2), .TIMEOUT(100)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .mode_req_valid_i(valid), .mode_req_i(mode), .mode_req_ready_o(ready),
    .frame_end_i(frame_end),
    .hd_o(hd), .hf_o(hf), .hr_o(hr), .hb_o(hb),
    .vd_o(vd), .vf_o(vf), .vr_o(vr), .vb_o(vb),
    .h_pol_o(hpol), .v_pol_o(vpol), .div_by_o(div_by),
    .we_o(we), .blank_o(blank), .busy_o(busy),
    .cur_mode_o(cur_mode), .timeout_o(timeout)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] hd, hf, hr, hb, vd, vf, vr, vb;
    logic        hpol, vpol;
    logic [15:0] div_by;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic request(input logic [1:0] m);
    valid = 1'b1;
    mode  = m;
    step();
    valid = 1'b0;
  endtask

  // From the LOAD cycle: leave LOAD, then two frames of settle back to IDLE.
  task automatic finish_settle(input string tag);
    step();
    chk({tag, "_settle_we"}, we, 1'b0);
    chk({tag, "_settle_blank"}, blank, 1'b1);
    frame_pulse();
    chk({tag, "_settle_ready1"}, ready, 1'b0);
    frame_pulse();
    chk({tag, "_idle_ready"}, ready, 1'b1);
    chk({tag, "_idle_blank"}, blank, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic saw_we;

    vecs[0] = '{2'd1, 12'd800,  12'd40, 12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1, 16'h51EC};
    vecs[1] = '{2'd3, 12'd1366, 12'd70, 12'd143, 12'd213, 12'd768, 12'd3,  12'd3, 12'd24, 1'b1, 1'b1, 16'hAF1B};
    vecs[2] = '{2'd0, 12'd640,  12'd16, 12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0, 16'h338F};
    vecs[3] = '{2'd2, 12'd1024, 12'd24, 12'd136, 12'd160, 12'd768, 12'd3,  12'd6, 12'd29, 1'b0, 1'b0, 16'h851F};

    arstn = 1'b0; valid = 1'b0; mode = 2'd0; frame_end = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_we", we, 1'b0);
    chk("rst_blank", blank, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_cur_mode", cur_mode, 2'd0);
    chk("rst_hd", hd, 12'd640);
    chk("rst_div", div_by, 16'h338F);

    // Boot: one BOOT cycle then the default mode is loaded
    arstn = 1'b1;
    step();
    chk("boot_we", we, 1'b1);
    chk("boot_hd", hd, 12'd640);
    chk("boot_vd", vd, 12'd480);
    chk("boot_div", div_by, 16'h338F);
    chk("boot_blank", blank, 1'b1);
    finish_settle("boot");

    // Same-mode request is consumed with no reload
    valid = 1'b1; mode = 2'd0;
    step();
    valid = 1'b0;
    chk("same_we", we, 1'b0);
    chk("same_busy", busy, 1'b0);
    chk("same_ready", ready, 1'b1);
    saw_we = 1'b0;
    repeat (5) begin step(); saw_we |= we | busy; end
    chk("same_quiet", saw_we, 1'b0);

    // Mid-frame request for mode 2: nothing loads until frame_end
    request(2'd2);
    chk("m2_ready", ready, 1'b0);
    chk("m2_busy", busy, 1'b1);
    chk("m2_blank_wait", blank, 1'b0);
    saw_we = 1'b0;
    repeat (6) begin step(); saw_we |= we; end
    chk("m2_no_we_wait", saw_we, 1'b0);
    chk("m2_hd_old", hd, 12'd640);
    frame_pulse();
    chk("m2_we", we, 1'b1);
    chk("m2_hd", hd, 12'd1024);
    chk("m2_hb", hb, 12'd160);
    chk("m2_vd", vd, 12'd768);
    chk("m2_vr", vr, 12'd6);
    chk("m2_div", div_by, 16'h851F);
    chk("m2_cur", cur_mode, 2'd2);
    chk("m2_timeout", timeout, 1'b0);
    finish_settle("m2");

    // Table-driven loads through every mode
    for (int i = 0; i < 4; i++) begin
      request(vecs[i].mode);
      repeat (3) step();
      frame_pulse();
      chk($sformatf("v%0d_we", i), we, 1'b1);
      chk($sformatf("v%0d_cur", i), cur_mode, vecs[i].mode);
      chk($sformatf("v%0d_h", i), {hd, hf, hr, hb}, {vecs[i].hd, vecs[i].hf, vecs[i].hr, vecs[i].hb});
      chk($sformatf("v%0d_v", i), {vd, vf, vr, vb}, {vecs[i].vd, vecs[i].vf, vecs[i].vr, vecs[i].vb});
      chk($sformatf("v%0d_pol_div", i), {hpol, vpol, div_by}, {vecs[i].hpol, vecs[i].vpol, vecs[i].div_by});
      finish_settle($sformatf("v%0d", i));
    end

    // Wait timeout: mode 3 with no frame_end, load at cycle 100 of the wait
    request(2'd3);
    cyc = 0;
    while (!we && cyc < 200) begin step(); cyc++; end
    chk("to_cycles", cyc, 100);
    chk("to_timeout", timeout, 1'b1);
    chk("to_hd", hd, 12'd1366);
    chk("to_div", div_by, 16'hAF1B);
    step();
    chk("to_pulse_end", timeout, 1'b0);
    chk("to_settle_blank", blank, 1'b1);
    // Settle frame ended by timer expiry
    cyc = 0;
    while (!timeout && cyc < 200) begin step(); cyc++; end
    chk("st_to_cycles", cyc, 100);
    chk("st_to_ready", ready, 1'b0);
    frame_pulse();
    chk("st_to_idle", ready, 1'b1);

    // frame_end coincident with wait expiry: load, no timeout
    request(2'd2);
    repeat (99) step();
    chk("co_still_wait", we, 1'b0);
    frame_pulse();
    chk("co_we", we, 1'b1);
    chk("co_timeout", timeout, 1'b0);
    chk("co_hd", hd, 12'd1024);
    chk("co_vd", vd, 12'd768);
    finish_settle("co");

    // Reset during a wait for mode 1
    request(2'd1);
    repeat (4) step();
    arstn = 1'b0;
    #1;
    chk("ar_hd", hd, 12'd640);
    chk("ar_div", div_by, 16'h338F);
    chk("ar_cur", cur_mode, 2'd0);
    chk("ar_blank_busy", {blank, busy, ready, we}, 4'b1100);
    repeat (2) step();
    arstn = 1'b1;
    step();
    chk("ar_boot_we", we, 1'b1);
    chk("ar_boot_cur", cur_mode, 2'd0);
    finish_settle("ar");
    saw_we = 1'b0;
    repeat (20) begin frame_pulse(); saw_we |= we | (cur_mode != 2'd0); end
    chk("ar_no_mode1", saw_we, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
